// File: rtl/vball_gfx_server_if.sv
// Bus bundle for vball_gfx_server.
// Carries the graphics-ROM byte read port (gfx_*) toward the background
// engine and the 16-bit word req/ack port (sdr_*) toward the SDRAM controller.
//   slave  : view of the cache server (takes gfx reads, issues SDRAM requests)
//   master : view of the surrounding system / bench (issues gfx reads, answers SDRAM)
interface vball_gfx_server_if;
  logic        gfx_read;
  logic [18:0] gfx_addr;
  logic [7:0]  gfx_data;
  logic        gfx_valid;
  logic        gfx_busy;
  logic        sdr_req;
  logic [17:0] sdr_addr;
  logic        sdr_ack;
  logic [15:0] sdr_data;

  modport slave (
    input  gfx_read, gfx_addr, sdr_ack, sdr_data,
    output gfx_data, gfx_valid, gfx_busy, sdr_req, sdr_addr
  );

  modport master (
    output gfx_read, gfx_addr, sdr_ack, sdr_data,
    input  gfx_data, gfx_valid, gfx_busy, sdr_req, sdr_addr
  );
endinterface

// File: rtl/vball_gfx_server.sv
// Graphics-ROM byte server for the background engine.
// Serves byte reads out of a 512 KB tile ROM in SDRAM through a two-line word
// cache: line A holds the demand word, line B the prefetched next word.
// Ports:
//   clk_sys  system clock, rising edge
//   reset    asynchronous, active-high
//   flush    level-sensitive cache invalidate (ROM download)
//   bus      slave side of vball_gfx_server_if (gfx_* read port, sdr_* word port)
module vball_gfx_server (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              flush,
  vball_gfx_server_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, PREFETCH = 2'd2} state_t;

  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic odd);
    return odd ? word[15:8] : word[7:0];
  endfunction

  state_t      state, state_n;
  logic        req, req_n;
  logic [17:0] req_addr, req_addr_n;
  logic [7:0]  rd_data, rd_data_n;
  logic        rd_valid, rd_valid_n;
  logic        busy, busy_n;
  logic        a_vld, a_vld_n, b_vld, b_vld_n;
  logic [17:0] a_tag, a_tag_n, b_tag, b_tag_n;
  logic [15:0] a_dat, a_dat_n, b_dat, b_dat_n;
  logic [18:0] pend_addr, pend_addr_n;
  logic        pend_match, pend_match_n;
  logic        q_pf, q_pf_n;
  logic [17:0] q_pf_addr, q_pf_addr_n;
  logic        stale, stale_n;
  logic        ack, wr_ok, accept, hit_a, hit_b;
  logic [17:0] rd_tag;

  assign ack    = bus.sdr_ack && req;
  // A request that saw flush at any point must not refill a line.
  assign wr_ok  = ack && !flush && !stale;
  assign accept = bus.gfx_read && !busy;
  assign rd_tag = bus.gfx_addr[18:1];

  assign bus.gfx_data  = rd_data;
  assign bus.gfx_valid = rd_valid;
  assign bus.gfx_busy  = busy;
  assign bus.sdr_req   = req;
  assign bus.sdr_addr  = req_addr;

  always_comb begin
    state_n      = state;
    req_n        = req;
    req_addr_n   = req_addr;
    rd_data_n    = rd_data;
    rd_valid_n   = 1'b0;
    busy_n       = busy;
    a_vld_n      = a_vld;
    a_tag_n      = a_tag;
    a_dat_n      = a_dat;
    b_vld_n      = b_vld;
    b_tag_n      = b_tag;
    b_dat_n      = b_dat;
    pend_addr_n  = pend_addr;
    pend_match_n = pend_match;
    q_pf_n       = q_pf;
    q_pf_addr_n  = q_pf_addr;
    hit_a        = 1'b0;
    hit_b        = 1'b0;

    // Ack first, so a read in the same cycle sees the refreshed lines.
    if (ack) begin
      req_n = 1'b0;
      if (state == FETCH || (busy && pend_match)) begin
        // Demand word arrived (own fetch or the prefetch it was waiting on).
        if (wr_ok) begin
          a_tag_n = req_addr;
          a_dat_n = bus.sdr_data;
          a_vld_n = 1'b1;
        end
        if (state == PREFETCH) b_vld_n = 1'b0;
        rd_data_n    = byte_sel(bus.sdr_data, pend_addr[0]);
        rd_valid_n   = 1'b1;
        busy_n       = 1'b0;
        pend_match_n = 1'b0;
        q_pf_n       = 1'b0;
        state_n      = PREFETCH;
        req_addr_n   = req_addr + 18'd1;
      end else begin
        if (wr_ok) begin
          b_tag_n = req_addr;
          b_dat_n = bus.sdr_data;
          b_vld_n = 1'b1;
        end
        if (busy) begin
          state_n    = FETCH;
          req_addr_n = pend_addr[18:1];
          q_pf_n     = 1'b0;
        end else if (q_pf) begin
          state_n    = PREFETCH;
          req_addr_n = q_pf_addr;
          q_pf_n     = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
    end else if (state != IDLE && !req) begin
      // Request parked for one low cycle; raise it now (prefetches wait out flush).
      if (state == PREFETCH && flush) state_n = IDLE;
      else                            req_n   = 1'b1;
    end

    if (accept) begin
      hit_a = a_vld_n && !flush && (a_tag_n == rd_tag);
      hit_b = b_vld_n && !flush && (b_tag_n == rd_tag);
      if (hit_a) begin
        rd_data_n  = byte_sel(a_dat_n, bus.gfx_addr[0]);
        rd_valid_n = 1'b1;
      end else if (hit_b) begin
        rd_data_n  = byte_sel(b_dat_n, bus.gfx_addr[0]);
        rd_valid_n = 1'b1;
        a_tag_n    = b_tag_n;
        a_dat_n    = b_dat_n;
        a_vld_n    = 1'b1;
        b_vld_n    = 1'b0;
        if (state_n == IDLE) begin
          state_n    = PREFETCH;
          req_n      = !ack;
          req_addr_n = b_tag_n + 18'd1;
        end else if (req_n) begin
          q_pf_n      = 1'b1;
          q_pf_addr_n = b_tag_n + 18'd1;
        end else begin
          req_addr_n = b_tag_n + 18'd1;
        end
      end else begin
        busy_n       = 1'b1;
        pend_addr_n  = bus.gfx_addr;
        pend_match_n = 1'b0;
        if (state_n == IDLE) begin
          state_n    = FETCH;
          req_n      = !ack;
          req_addr_n = rd_tag;
        end else if (req_n) begin
          pend_match_n = (rd_tag == req_addr_n);
        end else begin
          state_n    = FETCH;
          req_addr_n = rd_tag;
        end
      end
    end

    if (flush) begin
      a_vld_n = 1'b0;
      b_vld_n = 1'b0;
    end
    stale_n = (req_n && !req) ? flush : (stale || flush);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req        <= 1'b0;
      req_addr   <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      a_vld      <= 1'b0;
      b_vld      <= 1'b0;
      pend_addr  <= '0;
      pend_match <= 1'b0;
      q_pf       <= 1'b0;
      q_pf_addr  <= '0;
      stale      <= 1'b0;
    end else begin
      state      <= state_n;
      req        <= req_n;
      req_addr   <= req_addr_n;
      rd_data    <= rd_data_n;
      rd_valid   <= rd_valid_n;
      busy       <= busy_n;
      a_vld      <= a_vld_n;
      b_vld      <= b_vld_n;
      pend_addr  <= pend_addr_n;
      pend_match <= pend_match_n;
      q_pf       <= q_pf_n;
      q_pf_addr  <= q_pf_addr_n;
      stale      <= stale_n;
    end
  end

  // Line tags and data are qualified by the valid bits.
  always_ff @(posedge clk_sys) begin
    a_tag <= a_tag_n;
    a_dat <= a_dat_n;
    b_tag <= b_tag_n;
    b_dat <= b_dat_n;
  end

endmodule
